// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and saturating-count helper
package cpu_pkg;

    localparam int DEF_ADDR_W = 32;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // Widths up to 64 bits share one helper; callers cast in and out.
    function automatic logic [63:0] sat_step(
        input logic [63:0] val,
        input logic [63:0] max_val,
        input logic        inc,
        input logic        dec
    );
        logic [63:0] res;
        res = val;
        if (inc && (val != max_val)) begin
            res = val + 64'd1;
        end else if (dec && (val != 64'd0)) begin
            res = val - 64'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down counter with load, resets weakly not-taken
module sat_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] init_val,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'((64'd1 << (CNT_W - 1)) - 64'd1);
    localparam logic [63:0]      MAX_VAL = 64'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = init_val;
        end else begin
            count_d = CNT_W'(sat_step(64'(count_q), MAX_VAL, inc, dec));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating-counter direction prediction
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_pred_taken,
    output logic [ADDR_W-1:0] if_pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              ex_mispredict,
    output logic [ADDR_W-1:0] ex_redirect_pc,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int               IDX_W      = $clog2(ENTRIES);
    localparam int               TAG_W      = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(64'd1 << (CNT_W - 1));
    localparam logic [63:0]      PERF_MAX   = 64'({PERF_W{1'b1}});

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_d [ENTRIES];
    logic [CNT_W-1:0]   cnt   [ENTRIES];
    logic [ENTRIES-1:0] cnt_inc, cnt_dec, cnt_load;
    logic [PERF_W-1:0]  perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, upd;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
    assign upd    = ex_valid & ex_is_branch;

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit & cnt[if_idx][CNT_W-1];
    assign if_pred_target = if_pred_taken ? tgt_q[if_idx] : if_pc + ADDR_W'(4);

    assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_mispredict  = upd & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_target != ex_pred_target)));
    assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(4);

    always_comb begin
        valid_d  = valid_q;
        cnt_inc  = '0;
        cnt_dec  = '0;
        cnt_load = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            tag_d[i] = tag_q[i];
            tgt_d[i] = tgt_q[i];
            if (upd && (ex_idx == IDX_W'(i))) begin
                // Taken either refreshes a hit or allocates over whatever aliased here.
                if (ex_taken) begin
                    valid_d[i] = 1'b1;
                    tag_d[i]   = ex_tag;
                    tgt_d[i]   = ex_target;
                end
                cnt_inc[i]  = ex_hit & ex_taken;
                cnt_dec[i]  = ex_hit & ~ex_taken;
                cnt_load[i] = ~ex_hit & ex_taken;
            end
        end
    end

    always_comb begin
        perf_br_d  = PERF_W'(sat_step(64'(perf_br_q), PERF_MAX, upd, 1'b0));
        perf_mis_d = PERF_W'(sat_step(64'(perf_mis_q), PERF_MAX, ex_mispredict, 1'b0));
        if (perf_clr) begin
            perf_br_d  = '0;
            perf_mis_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= tag_d[i];
                tgt_q[i] <= tgt_d[i];
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (cnt_inc[g]),
            .dec     (cnt_dec[g]),
            .load    (cnt_load[g]),
            .init_val(CNT_WEAK_T),
            .count   (cnt[g])
        );
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed scoreboard bench for branch_predictor
module tb_branch_predictor;

    localparam int S_PT  = 0;
    localparam int S_PTG = 1;
    localparam int S_MIS = 2;
    localparam int S_RED = 3;
    localparam int S_PB  = 4;
    localparam int S_PM  = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'h0040_0010;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic        perf_clr = 1'b0;
    logic [3:0]  perf_branches, perf_mispredicts;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pb_m = 0;
    int   pm_m = 0;

    branch_predictor #(
        .ADDR_W(32), .ENTRIES(64), .CNT_W(2), .PERF_W(4)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
        .perf_clr(perf_clr), .perf_branches(perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_PT:    return {31'b0, if_pred_taken};
            S_PTG:   return if_pred_target;
            S_MIS:   return {31'b0, ex_mispredict};
            S_RED:   return ex_redirect_pc;
            S_PB:    return {28'b0, perf_branches};
            default: return {28'b0, perf_mispredicts};
        endcase
    endfunction

    task automatic expect_v(string name, int sel, logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic expect_pred(string name, logic taken, logic [31:0] tgt);
        expect_v({name, "_taken"}, S_PT, {31'b0, taken});
        expect_v({name, "_target"}, S_PTG, tgt);
    endtask

    task automatic expect_perf(string name);
        expect_v({name, "_pb"}, S_PB, pb_m);
        expect_v({name, "_pm"}, S_PM, pm_m);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic drive_ex(logic v, logic b, logic [31:0] pc, logic tk, logic [31:0] tgt,
                            logic ptk, logic [31:0] ptgt);
        ex_valid       = v;
        ex_is_branch   = b;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Advance one edge and track the perf counters from the driven stimulus.
    task automatic cycle();
        logic upd, mis;
        @(posedge clk);
        upd = ex_valid & ex_is_branch;
        mis = upd & ((ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target)));
        if (perf_clr) begin
            pb_m = 0;
            pm_m = 0;
        end else begin
            if (upd && pb_m != 15) pb_m++;
            if (mis && pm_m != 15) pm_m++;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Populate an entry, then reset asynchronously in the middle of a cycle.
        drive_ex(1, 1, 32'h0040_0010, 1, 32'h0040_0500, 0, 32'h0040_0014);
        cycle();
        idle_ex();
        if_pc = 32'h0040_0010;
        expect_pred("pre_reset", 1'b1, 32'h0040_0500);
        check_now();
        #2 rst = 1'b1;
        pb_m = 0;
        pm_m = 0;
        expect_pred("reset", 1'b0, 32'h0040_0014);
        expect_perf("reset");
        check_now();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Allocate on a taken miss.
        drive_ex(1, 1, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0040_0024);
        expect_v("alloc_mis", S_MIS, 32'd1);
        expect_v("alloc_red", S_RED, 32'h0040_0100);
        check_now();
        cycle();
        idle_ex();
        if_pc = 32'h0040_0020;
        expect_pred("alloc_pred", 1'b1, 32'h0040_0100);
        expect_v("alloc_pm", S_PM, 32'd1);
        expect_perf("alloc");
        check_now();

        // Hysteresis: 10 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01 -> 10.
        drive_ex(1, 1, 32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0100);
        expect_v("hit_ok_mis", S_MIS, 32'd0);
        check_now();
        cycle();
        drive_ex(1, 1, 32'h0040_0020, 0, 32'h0040_0100, 1, 32'h0040_0100);
        expect_v("nt1_mis", S_MIS, 32'd1);
        expect_v("nt1_red", S_RED, 32'h0040_0024);
        check_now();
        cycle();
        expect_pred("nt1_pred", 1'b1, 32'h0040_0100);
        check_now();
        cycle();
        expect_pred("nt2_pred", 1'b0, 32'h0040_0024);
        check_now();
        cycle();
        cycle();
        drive_ex(1, 1, 32'h0040_0020, 1, 32'h0040_0200, 0, 32'h0040_0024);
        cycle();
        idle_ex();
        expect_pred("sat0_pred", 1'b0, 32'h0040_0024);
        check_now();
        drive_ex(1, 1, 32'h0040_0020, 1, 32'h0040_0200, 0, 32'h0040_0024);
        cycle();
        idle_ex();
        expect_pred("retrain_pred", 1'b1, 32'h0040_0200);
        expect_perf("hyst");
        check_now();

        // Aliasing: same index 8, different tag.
        drive_ex(1, 1, 32'h0040_0120, 1, 32'h0040_0300, 0, 32'h0040_0124);
        cycle();
        idle_ex();
        if_pc = 32'h0040_0020;
        expect_pred("alias_old", 1'b0, 32'h0040_0024);
        check_now();
        if_pc = 32'h0040_0120;
        expect_pred("alias_new", 1'b1, 32'h0040_0300);
        check_now();

        // Same-cycle lookup and update of one index sees the old entry.
        drive_ex(1, 1, 32'h0040_0120, 0, 32'h0040_0300, 1, 32'h0040_0300);
        expect_pred("coll_dec_before", 1'b1, 32'h0040_0300);
        check_now();
        cycle();
        idle_ex();
        expect_pred("coll_dec_after", 1'b0, 32'h0040_0124);
        check_now();
        if_pc = 32'h0040_0040;
        drive_ex(1, 1, 32'h0040_0040, 1, 32'h0040_0800, 0, 32'h0040_0044);
        expect_pred("coll_alloc_before", 1'b0, 32'h0040_0044);
        check_now();
        cycle();
        idle_ex();
        expect_pred("coll_alloc_after", 1'b1, 32'h0040_0800);
        check_now();

        // No-op updates leave table and perf counters alone.
        drive_ex(0, 1, 32'h0040_0040, 0, 32'h0040_0800, 1, 32'h0040_0800);
        expect_v("noop_v_mis", S_MIS, 32'd0);
        check_now();
        cycle();
        drive_ex(1, 0, 32'h0040_0040, 0, 32'h0040_0800, 1, 32'h0040_0800);
        expect_v("noop_b_mis", S_MIS, 32'd0);
        check_now();
        cycle();
        idle_ex();
        expect_pred("noop_pred", 1'b1, 32'h0040_0800);
        expect_v("noop_pb", S_PB, 32'd11);
        expect_perf("noop");
        check_now();

        // PC+4 wraps at the top of the address space.
        if_pc = 32'hFFFF_FFFC;
        drive_ex(0, 0, 32'hFFFF_FFFC, 0, 32'h0000_1000, 0, 32'h0);
        expect_pred("wrap", 1'b0, 32'h0000_0000);
        expect_v("wrap_red", S_RED, 32'h0000_0000);
        check_now();
        idle_ex();

        // Perf saturation with a clear coinciding with update 3.
        for (int i = 1; i <= 20; i++) begin
            drive_ex(1, 1, 32'h0050_0000 + 32'(i * 4), 0, 32'h0, 1, 32'h0);
            perf_clr = (i == 3);
            cycle();
            if (i == 3) begin
                expect_v("clr_pb", S_PB, 32'd0);
                expect_v("clr_pm", S_PM, 32'd0);
                check_now();
            end
        end
        perf_clr = 1'b0;
        idle_ex();
        expect_v("sat_pb", S_PB, 32'd15);
        expect_v("sat_pm", S_PM, 32'd15);
        expect_perf("sat");
        check_now();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
